// File: rtl/seqgen_pkg.sv
// Shared types and constants for the serial sequence generator: state encoding,
// 7-segment glyphs and the LFSR feedback taps.
package seqgen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [7:0] SEG_DASH  = 8'h40;
  localparam logic [7:0] SEG_ALL   = 8'hFF;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  // Fibonacci step for x^8+x^6+x^5+x^4+1; the oldest bit leaves from bit 7.
  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {s[6:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational hex-to-7-segment decoder, output order {dp,g,f,e,d,c,b,a},
// active-high, dp always off.
module seg7_hex_decoder (
  input  logic [3:0] value,
  output logic [7:0] seg
);

  always_comb begin
    seg = 8'h00;
    case (value)
      4'h0: seg = 8'h3F;
      4'h1: seg = 8'h06;
      4'h2: seg = 8'h5B;
      4'h3: seg = 8'h4F;
      4'h4: seg = 8'h66;
      4'h5: seg = 8'h6D;
      4'h6: seg = 8'h7D;
      4'h7: seg = 8'h07;
      4'h8: seg = 8'h7F;
      4'h9: seg = 8'h6F;
      4'hA: seg = 8'h77;
      4'hB: seg = 8'h7C;
      4'hC: seg = 8'h39;
      4'hD: seg = 8'h5E;
      4'hE: seg = 8'h79;
      4'hF: seg = 8'h71;
      default: seg = 8'h00;
    endcase
  end

endmodule

// File: rtl/sequence_generator.sv
// Serial MSB-first pattern transmitter with optional repeats, idle gaps and a
// 7-segment progress display. Define SEQGEN_LFSR_EN to add the LFSR bit source.
//
// state | meaning
// IDLE  | line high, waiting for start
// SHIFT | sending pattern bit idx for one bit period
// GAP   | line high for one bit period between repetitions
// DONE  | one-cycle end-of-transmission marker
module sequence_generator #(
  parameter int BIT_DIV = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] pattern,
  input  logic [2:0] len,
  input  logic [3:0] rep,
  input  logic       lfsr_mode,
  output logic       x_out,
  output logic       busy,
  output logic       done,
  output logic [7:0] seg
);
  import seqgen_pkg::*;

  localparam logic [7:0] DIV_LAST = 8'(BIT_DIV - 1);

  state_t     state, state_d;
  logic [7:0] pat_q, pat_d;
  logic [2:0] len_q, len_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] rcnt_q, rcnt_d;
  logic [7:0] dcnt_q, dcnt_d;
  logic       x_d, busy_d, done_d;
  logic [7:0] seg_d, hex_seg;
  logic       bit_end, src_bit;

  assign bit_end = (dcnt_q == DIV_LAST);

  seg7_hex_decoder u_hex (
    .value (rcnt_q),
    .seg   (hex_seg)
  );

`ifdef SEQGEN_LFSR_EN
  logic [7:0] lfsr_q, lfsr_d;
  logic       mode_q, mode_d;
  assign src_bit = mode_q ? lfsr_q[7] : pat_q[idx_q];
`else
  logic unused_lfsr_mode;
  assign unused_lfsr_mode = lfsr_mode;
  assign src_bit = pat_q[idx_q];
`endif

  always_comb begin
    state_d = state;
    pat_d   = pat_q;
    len_d   = len_q;
    idx_d   = idx_q;
    rcnt_d  = rcnt_q;
    dcnt_d  = dcnt_q;
    x_d     = 1'b1;
    busy_d  = (state != IDLE);
    done_d  = (state == DONE);
    seg_d   = seg;
`ifdef SEQGEN_LFSR_EN
    lfsr_d  = lfsr_q;
    mode_d  = mode_q;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          pat_d   = pattern;
          len_d   = len;
          idx_d   = len;
          rcnt_d  = rep;
          dcnt_d  = 8'd0;
          state_d = SHIFT;
`ifdef SEQGEN_LFSR_EN
          lfsr_d  = (pattern == 8'd0) ? 8'h01 : pattern;
          mode_d  = lfsr_mode;
`endif
        end
      end
      SHIFT: begin
        x_d    = src_bit;
        seg_d  = hex_seg;
        dcnt_d = bit_end ? 8'd0 : dcnt_q + 8'd1;
        if (bit_end) begin
`ifdef SEQGEN_LFSR_EN
          lfsr_d = lfsr_step(lfsr_q);
`endif
          if (idx_q != 3'd0) begin
            idx_d = idx_q - 3'd1;
          end else if (rcnt_q == 4'd0) begin
            state_d = DONE;
          end else begin
            rcnt_d  = rcnt_q - 4'd1;
            state_d = GAP;
          end
        end
      end
      GAP: begin
        seg_d  = hex_seg;
        dcnt_d = bit_end ? 8'd0 : dcnt_q + 8'd1;
        if (bit_end) begin
          idx_d   = len_q;
          state_d = SHIFT;
        end
      end
      DONE: begin
        seg_d   = SEG_ALL;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      pat_q  <= 8'd0;
      len_q  <= 3'd0;
      idx_q  <= 3'd0;
      rcnt_q <= 4'd0;
      dcnt_q <= 8'd0;
      x_out  <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
      seg    <= SEG_DASH;
`ifdef SEQGEN_LFSR_EN
      lfsr_q <= 8'd0;
      mode_q <= 1'b0;
`endif
    end else begin
      state  <= state_d;
      pat_q  <= pat_d;
      len_q  <= len_d;
      idx_q  <= idx_d;
      rcnt_q <= rcnt_d;
      dcnt_q <= dcnt_d;
      x_out  <= x_d;
      busy   <= busy_d;
      done   <= done_d;
      seg    <= seg_d;
`ifdef SEQGEN_LFSR_EN
      lfsr_q <= lfsr_d;
      mode_q <= mode_d;
`endif
    end
  end

endmodule

// File: tb/tb_sequence_generator.sv
// Self-checking bench: two generators (BIT_DIV 1 and 3) share stimulus and are
// compared cycle by cycle against a bit-stream model built from the pattern rules.
module tb_sequence_generator;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] pattern = 8'h00;
  logic [2:0] len = 3'd0;
  logic [3:0] rep = 4'd0;
  logic       lfsr_mode = 1'b0;
  logic       x1, b1, dn1, x3, b3, dn3;
  logic [7:0] s1, s3;

  int total = 0;
  int bad = 0;

  bit   exp_x   [2][1024];
  int   exp_dig [2][1024];
  int   exp_n   [2];
  logic [7:0] hex_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                               8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  sequence_generator #(.BIT_DIV(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len), .rep(rep),
    .lfsr_mode(lfsr_mode), .x_out(x1), .busy(b1), .done(dn1), .seg(s1)
  );

  sequence_generator #(.BIT_DIV(3)) dut3 (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .len(len), .rep(rep),
    .lfsr_mode(lfsr_mode), .x_out(x3), .busy(b3), .done(dn3), .seg(s3)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] obs(int sel);
    return (sel != 0) ? {x3, b3, dn3, s3} : {x1, b1, dn1, s1};
  endfunction

  // Expected {x_out,busy,done,seg} k cycles after the accepting edge.
  function automatic logic [10:0] expected_at(int sel, int k);
    if (k < exp_n[sel])
      return {exp_x[sel][k-1], 1'b1, 1'b0, hex_tab[exp_dig[sel][k-1]]};
    if (k == exp_n[sel])
      return {1'b1, 1'b1, 1'b1, 8'hFF};
    return {1'b1, 1'b0, 1'b0, 8'hFF};
  endfunction

  task automatic build_model(input logic [7:0] pat, input int ln, input int rp, input bit lf);
    bit         bits [$];
    int         digs [$];
    logic [7:0] s;
    bit         use_lf;
    bit         b;
    int         p;
`ifdef SEQGEN_LFSR_EN
    use_lf = lf;
`else
    use_lf = lf & 1'b0;
`endif
    s = (pat == 8'h00) ? 8'h01 : pat;
    for (int r = 0; r <= rp; r++) begin
      for (int i = ln; i >= 0; i--) begin
        if (use_lf) begin
          b = s[7];
          s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
        end else begin
          b = pat[i];
        end
        bits.push_back(b);
        digs.push_back(rp - r);
      end
      if (r < rp) begin
        bits.push_back(1'b1);
        digs.push_back(rp - r - 1);
      end
    end
    for (int sel = 0; sel < 2; sel++) begin
      p = 0;
      for (int q = 0; q < bits.size(); q++) begin
        for (int d = 0; d < ((sel != 0) ? 3 : 1); d++) begin
          exp_x[sel][p]   = bits[q];
          exp_dig[sel][p] = digs[q];
          p++;
        end
      end
      exp_n[sel] = p + 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    start = 1'b0;
    tick();
    tick();
    for (int sel = 0; sel < 2; sel++) begin
      total++;
      if (obs(sel) !== {1'b1, 1'b0, 1'b0, 8'h40}) begin
        bad++;
        $display("FAIL reset_values dut%0d: got %h want %h", sel, obs(sel), {1'b1, 1'b0, 1'b0, 8'h40});
      end
    end
    start = 1'b1;
    tick();
    reset = 1'b0;
    start = 1'b0;
    tick();
    tick();
    for (int sel = 0; sel < 2; sel++) begin
      total++;
      if (obs(sel) !== {1'b1, 1'b0, 1'b0, 8'h40}) begin
        bad++;
        $display("FAIL reset_beats_start dut%0d: got %h want %h", sel, obs(sel), {1'b1, 1'b0, 1'b0, 8'h40});
      end
    end
  endtask

  // One transmission; with disturb set, start is re-pulsed and the inputs are
  // scrambled while both generators are busy.
  task automatic test_stream(input string name, input logic [7:0] pat, input int ln,
                             input int rp, input bit lf, input bit disturb);
    int last;
    build_model(pat, ln, rp, lf);
    pattern   = pat;
    len       = ln[2:0];
    rep       = rp[3:0];
    lfsr_mode = lf;
    start     = 1'b1;
    tick();
    start = 1'b0;
    last = ((exp_n[0] > exp_n[1]) ? exp_n[0] : exp_n[1]) + 2;
    for (int k = 1; k <= last; k++) begin
      tick();
      for (int sel = 0; sel < 2; sel++) begin
        total++;
        if (obs(sel) !== expected_at(sel, k)) begin
          bad++;
          $display("FAIL %s div%0d cycle %0d: got %h want %h", name, (sel != 0) ? 3 : 1, k,
                   obs(sel), expected_at(sel, k));
        end
      end
      if (disturb && k == 2) begin
        pattern = 8'hFF;
        len     = 3'd7;
        rep     = 4'd15;
        start   = 1'b1;
      end
      if (disturb && k == 3) start = 1'b0;
    end
  endtask

  task automatic test_send_once();
    test_stream("send_once", 8'h03, 2, 0, 1'b0, 1'b0);
  endtask

  task automatic test_repeat_div();
    test_stream("repeat_div", 8'h05, 2, 1, 1'b0, 1'b0);
  endtask

  task automatic test_ignored_inputs();
    test_stream("ignored_inputs", 8'h5A, 5, 1, 1'b0, 1'b1);
  endtask

  task automatic test_edge_lengths();
    test_stream("len0", 8'h00, 0, 0, 1'b0, 1'b0);
    test_stream("len7", 8'hA5, 7, 0, 1'b0, 1'b0);
    test_stream("len7_rep15", 8'hC3, 7, 15, 1'b0, 1'b0);
  endtask

  task automatic test_lfsr();
    test_stream("lfsr_seed0", 8'h00, 7, 0, 1'b1, 1'b0);
    test_stream("lfsr_rep", 8'h9E, 4, 2, 1'b1, 1'b0);
  endtask

  task automatic test_reset_mid();
    pattern = 8'hA5;
    len     = 3'd7;
    rep     = 4'd2;
    start   = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    for (int sel = 0; sel < 2; sel++) begin
      total++;
      if (obs(sel) !== {1'b1, 1'b0, 1'b0, 8'h40}) begin
        bad++;
        $display("FAIL reset_mid dut%0d: got %h want %h", sel, obs(sel), {1'b1, 1'b0, 1'b0, 8'h40});
      end
    end
    reset = 1'b0;
    tick();
    for (int sel = 0; sel < 2; sel++) begin
      total++;
      if (obs(sel) !== {1'b1, 1'b0, 1'b0, 8'h40}) begin
        bad++;
        $display("FAIL reset_mid_idle dut%0d: got %h want %h", sel, obs(sel), {1'b1, 1'b0, 1'b0, 8'h40});
      end
    end
    test_stream("after_reset", 8'h3C, 5, 1, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    int last;
    int kk;
    build_model(8'h02, 1, 0, 1'b0);
    pattern   = 8'h02;
    len       = 3'd1;
    rep       = 4'd0;
    lfsr_mode = 1'b0;
    start     = 1'b1;
    tick();
    last = 2 * ((exp_n[0] > exp_n[1]) ? exp_n[0] : exp_n[1]) + 1;
    for (int k = 1; k <= last; k++) begin
      tick();
      for (int sel = 0; sel < 2; sel++) begin
        if (k <= 2 * exp_n[sel] + 1) begin
          kk = (k > exp_n[sel] + 1) ? k - exp_n[sel] - 1 : k;
          total++;
          if (obs(sel) !== expected_at(sel, kk)) begin
            bad++;
            $display("FAIL back_to_back div%0d cycle %0d: got %h want %h", (sel != 0) ? 3 : 1, k,
                     obs(sel), expected_at(sel, kk));
          end
        end
      end
    end
    start = 1'b0;
    repeat (12) tick();
    for (int sel = 0; sel < 2; sel++) begin
      total++;
      if (obs(sel) !== {1'b1, 1'b0, 1'b0, 8'hFF}) begin
        bad++;
        $display("FAIL back_to_back_drain dut%0d: got %h want %h", sel, obs(sel), {1'b1, 1'b0, 1'b0, 8'hFF});
      end
    end
  endtask

  task automatic test_random();
    logic [7:0] p;
    int         l, r;
    bit         m;
    for (int n = 0; n < 8; n++) begin
      p = 8'($urandom_range(0, 255));
      l = $urandom_range(0, 7);
      r = $urandom_range(0, 3);
      m = 1'($urandom_range(0, 1));
      test_stream($sformatf("random%0d", n), p, l, r, m, 1'b0);
    end
  endtask

  initial begin
    test_reset();
    test_send_once();
    test_repeat_div();
    test_ignored_inputs();
    test_edge_lengths();
    test_lfsr();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
